ahb_sram_slave: RTL

//  Simplified-AHB data-memory slave; sits directly downstream of the memory access unit on the data bus.

---
 rtl/ahb_sram_slave.sv | 111 +++++++++++
 1 files changed

// File: rtl/ahb_sram_slave.sv
// Simplified-AHB data-memory slave: single NONSEQ transfers into a word-wide SRAM with byte lanes,
// programmable wait states and a two-cycle ERROR response for illegal accesses.
module ahb_sram_slave #(
  parameter int unsigned MEM_AW      = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP
);

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  localparam logic [3:0] WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e            state;
  logic [3:0]        cnt;
  logic [MEM_AW-1:0] word_idx;
  logic [1:0]        lane;
  logic [2:0]        size;
  logic              write;

  logic [31:0] mem [2**MEM_AW];

  logic       addr_phase;
  logic       illegal;
  logic       hi_bits_set;
  logic [3:0] strobe;
  logic       unused_htrans0;

  // SEQ is treated as NONSEQ, so only HTRANS[1] matters.
  assign unused_htrans0 = HTRANS[0];

  assign HREADY      = (state == StIdle) || (state == StData) || (state == StErr2);
  assign HRESP       = ((state == StErr1) || (state == StErr2)) ? 2'b01 : 2'b00;
  assign addr_phase  = HREADY && HSEL && HTRANS[1];
  assign hi_bits_set = |(HADDR >> (MEM_AW + 2));
  assign HRDATA      = ((state == StData) && !write) ? mem[word_idx] : 32'h0;

  always_comb begin
    illegal = hi_bits_set;
    if (HSIZE > 3'b010) illegal = 1'b1;
    if ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00)) illegal = 1'b1;
    if ((HSIZE == 3'b001) && HADDR[0]) illegal = 1'b1;
  end

  always_comb begin
    strobe = 4'b0000;
    case (size)
      3'b000:  strobe = 4'b0001 << lane;
      3'b001:  strobe = lane[1] ? 4'b1100 : 4'b0011;
      default: strobe = 4'b1111;
    endcase
  end

  // Memory contents survive reset; a write in flight when reset hits is dropped.
  always_ff @(posedge clk) begin
    if (!reset && (state == StData) && write) begin
      for (int b = 0; b < 4; b++) begin
        if (strobe[b]) mem[word_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= StIdle;
      cnt      <= 4'd0;
      word_idx <= '0;
      lane     <= 2'b00;
      size     <= 3'b000;
      write    <= 1'b0;
    end else begin
      unique case (state)
        StWait: begin
          if (cnt == 4'd0) state <= StData;
          else             cnt   <= cnt - 4'd1;
        end
        StErr1: state <= StErr2;
        default: begin
          // Idle, Data and Err2 all have HREADY high and accept the next address phase.
          if (addr_phase) begin
            word_idx <= HADDR[MEM_AW+1:2];
            lane     <= HADDR[1:0];
            size     <= HSIZE;
            write    <= HWRITE;
            if (illegal) begin
              state <= StErr1;
            end else if (WAIT_CYCLES != 0) begin
              state <= StWait;
              cnt   <= WaitInit;
            end else begin
              state <= StData;
            end
          end else begin
            state <= StIdle;
          end
        end
      endcase
    end
  end

endmodule
